multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Control FSM for the multicycle processor variant. It reuses the existing register file, ALU and immediate paths, and splits each instruction into fetch, decode, execute, memory and writeback steps over one shared instruction/data memory. It generates per-cycle enables and selects for the datapath, handshakes with memory, and counts retired instructions. Opcode, func, ALU op and ALU source encodings come from `_const.v`.

Parameters:
COUNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
instruction  in  32  current IR contents (datapath-owned register, loaded via ir_write)
alu_zero  in  1  ALU zero flag from the current EXEC cycle
mem_ready  in  1  memory accepted/completed the current request this cycle
mem_req  out  1  memory request strobe
mem_write  out  1  1 = store, valid only with mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALU result register
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC this cycle
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target (addr26)
alu_op  out  3  per `_const.v` OP_*
alu_src  out  2  per `_const.v` ALU_SRC_*
shamt  out  5  shift amount for SLL/SRL
reg_write  out  1  register-file write enable
wb_sel  out  1  0 = ALU result, 1 = memory data register
addr_a, addr_b, addr_in  out  5 each  register-file addresses
state  out  3  current state, for debug/bench
illegal  out  1  sticky; unsupported opcode/func decoded
retired  out  COUNT_W  instructions completed since reset

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- On rst (async): state=FETCH, retired=0, illegal=0, every other output 0.
- All control outputs are Moore, decoded from state and the latched instruction. No output depends combinationally on mem_ready, except that pc_write and ir_write in FETCH are gated by mem_ready.
- FETCH:
  - Drives mem_req=1, mem_write=0, mem_addr_sel=0.
  - Holds until mem_ready=1. In that same cycle it asserts ir_write=1, pc_write=1 and pc_src=0, then goes to DECODE.
  - Zero-wait memory makes FETCH a single cycle.
- DECODE:
  - Drives addr_a=rs and addr_b=rt.
  - Supported opcode → EXEC. Unsupported opcode, or R-type with an unsupported func → TRAP with illegal=1.
- EXEC, by instruction class:
  - R-type ALU (ADD, SUB, AND, OR, NOR, SLT): alu_src=DATA_B, go to WB.
  - SLL/SRL: addr_a=rt, shamt=instruction[10:6], go to WB.
  - ADDI: alu_src=SEXT_IMM16, go to WB.
  - ANDI/ORI: alu_src=ZEXT_IMM16, go to WB.
  - LW/SW: alu_op=ADD, alu_src=SEXT_IMM16, go to MEM.
  - BEQ/BNE: alu_op=SUB, alu_src=DATA_B. pc_write is asserted when alu_zero (BEQ) or !alu_zero (BNE) holds, with pc_src=1. Then FETCH.
  - J: pc_write=1, pc_src=2, then FETCH.
- MEM:
  - Drives mem_req=1 and mem_addr_sel=1, with mem_write=1 for SW.
  - Waits for mem_ready. Then SW → FETCH, LW → WB.
- WB:
  - reg_write=1 for exactly one cycle.
  - wb_sel=1 for LW, 0 otherwise.
  - addr_in=rd for R-type, rt for I-type. Then FETCH.
- retired increments by 1 on the last cycle of each instruction, i.e. on any transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^COUNT_W.
- Latency with zero-wait memory:
  - R-type / I-type ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch / J: 3 cycles.
  - Each wait cycle (mem_ready low) adds one cycle.
- While mem_req=1 and mem_ready=0, mem_req, mem_write and mem_addr_sel stay stable.
- TRAP is absorbing until rst: illegal=1, all enables 0, retired frozen.
- rst mid-instruction (including mid-wait) aborts immediately with no reg_write or pc_write side effect, and returns to FETCH.
- Writes to addr_in=0 are still issued; the register file ignores them.

Decomposition:
- New `_const.v` entries: state encodings (ST_FETCH etc.), PC_SRC_* and WB_SEL_*. Reuse the existing OPCODE_*, FUNC_*, OP_* and ALU_SRC_* constants.
- Sub-module `instr_class_decode` (combinational): maps opcode/func to class {RALU, SHIFT, IALU_S, IALU_Z, LOAD, STORE, BRANCH, JUMP, ILLEGAL} and alu_op. The FSM lives in the top module.

Test Plan:
- ADD rd=3 rs=1 rt=2, mem_ready tied 1 → states 0,1,2,4,0. reg_write high only in cycle 4 with addr_in=3, wb_sel=0. retired 0→1.
- LW rt=5, mem_ready low for 2 cycles in MEM → 7 cycles total. mem_req/mem_addr_sel=1 stable through the wait, wb_sel=1, addr_in=5, retired+1.
- SW, then BEQ with alu_zero=1, then BNE with alu_zero=1:
  - SW: mem_write=1 in MEM, no reg_write.
  - BEQ: pc_write=1, pc_src=1.
  - BNE: pc_write=0.
  - retired=3.
- Unsupported opcode (e.g. OPCODE_LW+1 if unassigned) → TRAP, illegal=1 held for 20 cycles. retired frozen, mem_req=0.
- Assert rst during FETCH wait, then during WB → outputs 0 immediately, state=FETCH, retired=0, illegal cleared.
- Preload retired near wrap (COUNT_W=4, 16 ADDIs) → counter wraps 15→0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - encodings and instruction classes shared by the multicycle sequencer
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU, CLS_SHIFT, CLS_IALU_S, CLS_IALU_Z, CLS_LOAD,
        CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OPCODE_RTYPE = 6'd0,  OPCODE_J    = 6'd2,
                           OPCODE_BEQ   = 6'd4,  OPCODE_BNE  = 6'd5,
                           OPCODE_ADDI  = 6'd8,  OPCODE_ANDI = 6'd12,
                           OPCODE_ORI   = 6'd13, OPCODE_LW   = 6'd35,
                           OPCODE_SW    = 6'd43;

    localparam logic [5:0] FUNC_SLL = 6'd0,  FUNC_SRL = 6'd2,
                           FUNC_ADD = 6'd32, FUNC_SUB = 6'd34,
                           FUNC_AND = 6'd36, FUNC_OR  = 6'd37,
                           FUNC_NOR = 6'd39, FUNC_SLT = 6'd42;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                           OP_NOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

    localparam logic [1:0] ALU_SRC_DATA_B = 2'd0, ALU_SRC_SEXT_IMM16 = 2'd1,
                           ALU_SRC_ZEXT_IMM16 = 2'd2;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0, PC_SRC_BRANCH = 2'd1, PC_SRC_JUMP = 2'd2;

    localparam logic WB_SEL_ALU = 1'b0, WB_SEL_MEM = 1'b1;

    // R-format instructions write rd; everything else that writes back uses rt
    function automatic logic writes_rd(input instr_class_t c);
        return (c == CLS_RALU) || (c == CLS_SHIFT);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_instr_class_decode.sv
// rtl/multicycle_sequencer_instr_class_decode.sv - opcode/func to instruction class and ALU operation
module instr_class_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   func,
    output instr_class_t instr_class,
    output logic [2:0]   alu_op
);

    // anything not listed falls through to ILLEGAL so the FSM traps on it
    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_op      = OP_ADD;
        case (opcode)
            OPCODE_RTYPE: begin
                case (func)
                    FUNC_ADD: begin instr_class = CLS_RALU;  alu_op = OP_ADD; end
                    FUNC_SUB: begin instr_class = CLS_RALU;  alu_op = OP_SUB; end
                    FUNC_AND: begin instr_class = CLS_RALU;  alu_op = OP_AND; end
                    FUNC_OR:  begin instr_class = CLS_RALU;  alu_op = OP_OR;  end
                    FUNC_NOR: begin instr_class = CLS_RALU;  alu_op = OP_NOR; end
                    FUNC_SLT: begin instr_class = CLS_RALU;  alu_op = OP_SLT; end
                    FUNC_SLL: begin instr_class = CLS_SHIFT; alu_op = OP_SLL; end
                    FUNC_SRL: begin instr_class = CLS_SHIFT; alu_op = OP_SRL; end
                    default:  ;
                endcase
            end
            OPCODE_ADDI: begin instr_class = CLS_IALU_S; alu_op = OP_ADD; end
            OPCODE_ANDI: begin instr_class = CLS_IALU_Z; alu_op = OP_AND; end
            OPCODE_ORI:  begin instr_class = CLS_IALU_Z; alu_op = OP_OR;  end
            OPCODE_LW:   begin instr_class = CLS_LOAD;   alu_op = OP_ADD; end
            OPCODE_SW:   begin instr_class = CLS_STORE;  alu_op = OP_ADD; end
            OPCODE_BEQ, OPCODE_BNE: begin instr_class = CLS_BRANCH; alu_op = OP_SUB; end
            OPCODE_J:    begin instr_class = CLS_JUMP;   alu_op = OP_ADD; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - control FSM splitting each instruction into fetch/decode/exec/mem/wb steps
module multicycle_sequencer #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               mem_addr_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_op,
    output logic [1:0]         alu_src,
    output logic [4:0]         shamt,
    output logic               reg_write,
    output logic               wb_sel,
    output logic [4:0]         addr_a,
    output logic [4:0]         addr_b,
    output logic [4:0]         addr_in,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    import multicycle_sequencer_pkg::*;

    state_t       state_r;
    state_t       state_nxt;
    instr_class_t cls;
    logic [2:0]   dec_alu_op;
    logic         retire;

    wire [4:0] rs     = instruction[25:21];
    wire [4:0] rt     = instruction[20:16];
    wire [4:0] rd     = instruction[15:11];
    wire       is_bne = (instruction[31:26] == OPCODE_BNE);

    instr_class_decode u_decode (
        .opcode      (instruction[31:26]),
        .func        (instruction[5:0]),
        .instr_class (cls),
        .alu_op      (dec_alu_op)
    );

    assign state  = state_r;
    assign retire = (state_nxt == ST_FETCH) &&
                    ((state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB));

    // next state and Moore controls; everything is held low while rst is asserted
    always_comb begin
        state_nxt    = state_r;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        alu_op       = OP_ADD;
        alu_src      = ALU_SRC_DATA_B;
        shamt        = 5'd0;
        reg_write    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        addr_a       = 5'd0;
        addr_b       = 5'd0;
        addr_in      = 5'd0;
        if (!rst) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    addr_a    = rs;
                    addr_b    = rt;
                    state_nxt = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    addr_a = rs;
                    addr_b = rt;
                    alu_op = dec_alu_op;
                    case (cls)
                        CLS_RALU: state_nxt = ST_WB;
                        CLS_SHIFT: begin
                            addr_a    = rt;
                            shamt     = instruction[10:6];
                            state_nxt = ST_WB;
                        end
                        CLS_IALU_S: begin
                            alu_src   = ALU_SRC_SEXT_IMM16;
                            state_nxt = ST_WB;
                        end
                        CLS_IALU_Z: begin
                            alu_src   = ALU_SRC_ZEXT_IMM16;
                            state_nxt = ST_WB;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_src   = ALU_SRC_SEXT_IMM16;
                            state_nxt = ST_MEM;
                        end
                        CLS_BRANCH: begin
                            pc_src    = PC_SRC_BRANCH;
                            pc_write  = is_bne ? !alu_zero : alu_zero;
                            state_nxt = ST_FETCH;
                        end
                        CLS_JUMP: begin
                            pc_src    = PC_SRC_JUMP;
                            pc_write  = 1'b1;
                            state_nxt = ST_FETCH;
                        end
                        default: state_nxt = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_write    = (cls == CLS_STORE);
                    if (mem_ready) state_nxt = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (cls == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                    addr_in   = writes_rd(cls) ? rd : rt;
                    state_nxt = ST_FETCH;
                end
                ST_TRAP: state_nxt = ST_TRAP;
                default: state_nxt = ST_FETCH;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_FETCH;
        else     state_r <= state_nxt;
    end

    // sticky illegal flag and retired-instruction counter (wraps naturally)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (state_nxt == ST_TRAP) illegal <= 1'b1;
            if (retire) retired <= retired + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for the multicycle sequencer
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        alu_zero, mem_ready;
    logic        mem_req, mem_write, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src;
    logic [2:0]  alu_op, state;
    logic [4:0]  shamt, addr_a, addr_b, addr_in;
    logic        reg_write, wb_sel, illegal;
    logic [3:0]  retired;

    multicycle_sequencer #(.COUNT_W(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src), .shamt(shamt),
        .reg_write(reg_write), .wb_sel(wb_sel), .addr_a(addr_a), .addr_b(addr_b),
        .addr_in(addr_in), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] addr; logic sel; } wb_exp_t;
    wb_exp_t    exp_wb[$];
    logic       exp_mem[$];
    logic [1:0] exp_pc[$];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;
    logic [29:0] trace;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_ctrl();
        return |{mem_req, mem_write, mem_addr_sel, ir_write, pc_write, pc_src, alu_op,
                 alu_src, shamt, reg_write, wb_sel, addr_a, addr_b, addr_in};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OPCODE_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // monitor: pops the scoreboard whenever the DUT presents a write-back, memory or PC event
    wb_exp_t    m_wb;
    logic       m_mw;
    logic [1:0] m_pc;
    always @(negedge clk) begin
        if (!rst) begin
            if (reg_write) begin
                if (exp_wb.size() == 0) check("wb_unexpected", 32'(addr_in), 32'hffff_ffff);
                else begin
                    m_wb = exp_wb.pop_front();
                    check("wb_addr_in", 32'(addr_in), 32'(m_wb.addr));
                    check("wb_sel", 32'(wb_sel), 32'(m_wb.sel));
                    check("wb_state", 32'(state), 32'(ST_WB));
                end
            end
            if (state == ST_MEM && mem_req && mem_ready) begin
                if (exp_mem.size() == 0) check("mem_unexpected", 32'(mem_write), 32'hffff_ffff);
                else begin
                    m_mw = exp_mem.pop_front();
                    check("mem_write", 32'(mem_write), 32'(m_mw));
                    check("mem_addr_sel", 32'(mem_addr_sel), 32'd1);
                end
            end
            if (pc_write && state != ST_FETCH) begin
                if (exp_pc.size() == 0) check("pc_unexpected", 32'(pc_src), 32'hffff_ffff);
                else begin
                    m_pc = exp_pc.pop_front();
                    check("pc_src", 32'(pc_src), 32'(m_pc));
                    check("pc_state", 32'(state), 32'(ST_EXEC));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_ret = 0;
    endtask

    // drives one instruction from FETCH until it is back in FETCH (or trapped)
    task automatic run_instr(input string name, input logic [31:0] instr, input int fwait,
                             input int mwait, input logic zero, input int exp_cyc,
                             input bit retires, input int e_op, input int e_src,
                             input int e_shamt, input int e_addr_a);
        int cyc = 0; int fw = 0; int mw = 0;
        bit left = 0; bit done = 0; bit exec_seen = 0;
        instruction = instr;
        alu_zero = zero;
        trace = '0;
        while (!done && cyc < 40) begin
            if (state == ST_FETCH)    mem_ready = (fw >= fwait);
            else if (state == ST_MEM) mem_ready = (mw >= mwait);
            else                      mem_ready = 1'b1;
            @(negedge clk);
            trace = {trace[26:0], state};
            if (state == ST_FETCH) begin
                check({name, "_fetch_req"}, 32'({mem_req, mem_write, mem_addr_sel}), 32'b100);
                check({name, "_fetch_load"}, 32'({ir_write, pc_write, pc_src}),
                      mem_ready ? 32'b1100 : 32'b0);
                fw++;
            end
            if (state == ST_MEM) begin
                check({name, "_mem_drive"}, 32'({mem_req, mem_addr_sel, mem_write}),
                      32'({2'b11, instr[31:26] == OPCODE_SW}));
                mw++;
            end
            if (state == ST_EXEC && !exec_seen) begin
                exec_seen = 1;
                if (e_addr_a >= 0) check({name, "_addr_a"}, 32'(addr_a), e_addr_a);
                if (e_op >= 0)     check({name, "_alu_op"}, 32'(alu_op), e_op);
                if (e_src >= 0)    check({name, "_alu_src"}, 32'(alu_src), e_src);
                if (e_shamt >= 0)  check({name, "_shamt"}, 32'(shamt), e_shamt);
            end
            if (state != ST_FETCH) left = 1;
            @(posedge clk);
            #1;
            cyc++;
            if ((state == ST_FETCH && left) || state == ST_TRAP) done = 1;
        end
        check({name, "_cycles"}, cyc, exp_cyc);
        if (retires) exp_ret++;
        check({name, "_retired"}, 32'(retired), 32'(exp_ret % 16));
    endtask

    logic [5:0] fn_tab [5];
    int         op_tab [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; instruction = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        fn_tab = '{FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_NOR, FUNC_SLT};
        op_tab = '{int'(OP_SUB), int'(OP_AND), int'(OP_OR), int'(OP_NOR), int'(OP_SLT)};
        #2;
        check("rst_outputs", 32'(any_ctrl()), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired_illegal", 32'({retired, illegal}), 32'd0);
        do_reset();

        exp_wb.push_back('{addr: 5'd3, sel: 1'b0});
        run_instr("add", r_ins(5'd1, 5'd2, 5'd3, 5'd0, FUNC_ADD), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_DATA_B), -1, 1);
        check("add_trace", 32'(trace), 32'(30'o0124));

        exp_mem.push_back(1'b0);
        exp_wb.push_back('{addr: 5'd5, sel: 1'b1});
        run_instr("lw_wait", i_ins(OPCODE_LW, 5'd4, 5'd5, 16'h0008), 0, 2, 1'b0, 7, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_SEXT_IMM16), -1, 4);
        check("lw_trace", 32'(trace), 32'(30'o0123334));

        exp_wb.push_back('{addr: 5'd7, sel: 1'b0});
        run_instr("add_fwait", r_ins(5'd1, 5'd2, 5'd7, 5'd0, FUNC_ADD), 2, 0, 1'b0, 6, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_DATA_B), -1, 1);

        exp_mem.push_back(1'b1);
        run_instr("sw", i_ins(OPCODE_SW, 5'd7, 5'd6, 16'h0004), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_SEXT_IMM16), -1, 7);
        exp_pc.push_back(PC_SRC_BRANCH);
        run_instr("beq_taken", i_ins(OPCODE_BEQ, 5'd1, 5'd2, 16'hfffc), 0, 0, 1'b1, 3, 1'b1,
                  int'(OP_SUB), int'(ALU_SRC_DATA_B), -1, 1);
        run_instr("bne_not", i_ins(OPCODE_BNE, 5'd1, 5'd2, 16'h0010), 0, 0, 1'b1, 3, 1'b1,
                  int'(OP_SUB), int'(ALU_SRC_DATA_B), -1, 1);
        exp_pc.push_back(PC_SRC_BRANCH);
        run_instr("bne_taken", i_ins(OPCODE_BNE, 5'd3, 5'd2, 16'h0010), 0, 0, 1'b0, 3, 1'b1,
                  int'(OP_SUB), int'(ALU_SRC_DATA_B), -1, 3);
        run_instr("beq_not", i_ins(OPCODE_BEQ, 5'd3, 5'd2, 16'h0010), 0, 0, 1'b0, 3, 1'b1,
                  int'(OP_SUB), int'(ALU_SRC_DATA_B), -1, 3);
        exp_pc.push_back(PC_SRC_JUMP);
        run_instr("j", {OPCODE_J, 26'h0000123}, 0, 0, 1'b0, 3, 1'b1, -1, -1, -1, -1);

        exp_wb.push_back('{addr: 5'd9, sel: 1'b0});
        run_instr("addi", i_ins(OPCODE_ADDI, 5'd1, 5'd9, 16'h8001), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_SEXT_IMM16), -1, 1);
        exp_wb.push_back('{addr: 5'd10, sel: 1'b0});
        run_instr("andi", i_ins(OPCODE_ANDI, 5'd2, 5'd10, 16'h00ff), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_AND), int'(ALU_SRC_ZEXT_IMM16), -1, 2);
        exp_wb.push_back('{addr: 5'd11, sel: 1'b0});
        run_instr("ori", i_ins(OPCODE_ORI, 5'd3, 5'd11, 16'hf000), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_OR), int'(ALU_SRC_ZEXT_IMM16), -1, 3);
        exp_wb.push_back('{addr: 5'd12, sel: 1'b0});
        run_instr("sll", r_ins(5'd17, 5'd13, 5'd12, 5'd7, FUNC_SLL), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_SLL), -1, 7, 13);
        exp_wb.push_back('{addr: 5'd15, sel: 1'b0});
        run_instr("srl", r_ins(5'd17, 5'd14, 5'd15, 5'd31, FUNC_SRL), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_SRL), -1, 31, 14);
        for (int i = 0; i < 5; i++) begin
            exp_wb.push_back('{addr: 5'(16 + i), sel: 1'b0});
            run_instr("ralu", r_ins(5'd8, 5'd9, 5'(16 + i), 5'd0, fn_tab[i]), 0, 0, 1'b0, 4,
                      1'b1, op_tab[i], int'(ALU_SRC_DATA_B), -1, 8);
        end
        exp_wb.push_back('{addr: 5'd0, sel: 1'b0});
        run_instr("add_r0", r_ins(5'd1, 5'd2, 5'd0, 5'd0, FUNC_ADD), 0, 0, 1'b0, 4, 1'b1,
                  int'(OP_ADD), int'(ALU_SRC_DATA_B), -1, 1);

        // reset while in WB: the write must never appear
        instruction = r_ins(5'd1, 5'd2, 5'd3, 5'd0, FUNC_ADD);
        mem_ready = 1'b1;
        for (int k = 0; k < 10 && state != ST_WB; k++) begin
            @(posedge clk);
            #1;
        end
        check("wb_reached", 32'(state), 32'(ST_WB));
        rst = 1'b1;
        #1;
        check("rst_wb_outputs", 32'(any_ctrl()), 32'd0);
        check("rst_wb_state", 32'(state), 32'd0);
        check("rst_wb_retired", 32'(retired), 32'd0);
        do_reset();

        run_instr("illegal_op", i_ins(6'd36, 5'd1, 5'd2, 16'h0000), 0, 0, 1'b0, 2, 1'b0,
                  -1, -1, -1, -1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("trap_state", 32'(state), 32'(ST_TRAP));
            check("trap_illegal", 32'(illegal), 32'd1);
            check("trap_outputs", 32'(any_ctrl()), 32'd0);
            check("trap_retired", 32'(retired), 32'd0);
        end
        do_reset();
        check("rst_clears_illegal", 32'(illegal), 32'd0);
        check("rst_after_trap_state", 32'(state), 32'd0);

        for (int i = 0; i < 2; i++) begin
            exp_wb.push_back('{addr: 5'd4, sel: 1'b0});
            run_instr("add_pre", r_ins(5'd1, 5'd2, 5'd4, 5'd0, FUNC_ADD), 0, 0, 1'b0, 4, 1'b1,
                      int'(OP_ADD), int'(ALU_SRC_DATA_B), -1, 1);
        end
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check("fetch_wait_req", 32'({mem_req, ir_write, pc_write}), 32'b100);
        rst = 1'b1;
        #1;
        check("rst_fetch_outputs", 32'(any_ctrl()), 32'd0);
        check("rst_fetch_state_retired", 32'({state, retired}), 32'd0);
        do_reset();

        run_instr("illegal_func", r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'd33), 0, 0, 1'b0, 2, 1'b0,
                  -1, -1, -1, -1);
        check("illegal_func_flag", 32'({state, illegal}), 32'({ST_TRAP, 1'b1}));
        do_reset();

        for (int i = 0; i < 16; i++) begin
            exp_wb.push_back('{addr: 5'd9, sel: 1'b0});
            run_instr("wrap_addi", i_ins(OPCODE_ADDI, 5'd1, 5'd9, 16'h0001), 0, 0, 1'b0, 4, 1'b1,
                      int'(OP_ADD), int'(ALU_SRC_SEXT_IMM16), -1, 1);
            if (i == 14) check("wrap_pre", 32'(retired), 32'd15);
        end
        check("wrap_post", 32'(retired), 32'd0);

        repeat (2) @(posedge clk);
        check("sb_wb_empty", exp_wb.size(), 0);
        check("sb_mem_empty", exp_mem.size(), 0);
        check("sb_pc_empty", exp_pc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
